// File: rtl/clk_en_gen_pkg.sv
// Shared definitions for the clock-enable generator: CTRL field positions,
// reset value, synchroniser depth limits and the writable-bit mask helper.
// Latency: n/a (definitions only). Backpressure: n/a.
package clk_en_gen_pkg;

  localparam int          EN_BIT    = 15;
  localparam int          SEL_BIT   = 14;
  localparam logic [15:0] CTRL_RST  = 16'h8000;
  localparam int          SYNC_MIN  = 2;
  localparam int          SYNC_MAX  = 4;

  // Bits of CTRL that are actually stored; everything else reads as 0.
  function automatic logic [15:0] ctrl_mask(input int div_w);
    logic [15:0] m;
    m = '0;
    m[EN_BIT]  = 1'b1;
    m[SEL_BIT] = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < div_w) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/clk_en_div.sv
// One channel divider: counts source ticks, strobes clk_en on every DIV+1th tick.
// Latency: clk_en is registered, one mclk after the qualifying src tick.
// Backpressure: none; clr (config write or channel disabled) overrides src.
// Ports: mclk, reset_n (async, active low), src (tick), clr (restart phase),
//        div (terminal count), clk_en (one-cycle strobe).
module clk_en_div #(
  parameter int DIV_W = 8
) (
  input  logic             mclk,
  input  logic             reset_n,
  input  logic             src,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             clk_en
);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      clk_en <= 1'b0;
    end else if (clr) begin
      // A config write restarts the phase and suppresses any strobe this cycle.
      cnt    <= '0;
      clk_en <= 1'b0;
    end else if (src) begin
      if (cnt == div) begin
        cnt    <= '0;
        clk_en <= 1'b1;
      end else begin
        cnt    <= cnt + DIV_W'(1);
        clk_en <= 1'b0;
      end
    end else begin
      // No tick (gated or waiting on LFXT): hold phase, no strobe.
      clk_en <= 1'b0;
    end
  end

endmodule

// File: rtl/clk_en_gen.sv
// NCH-channel clock-enable generator with per-channel source, divider, enable and gate.
// Latency: strobe one mclk after src; LFXT edge reaches src SYNC_STAGES+1 mclk after lfxt_clk rises.
// Backpressure: none; peripheral bus reads are combinational, writes take effect next mclk.
// Ports: mclk, reset_n, lfxt_clk (async), oscoff, gate[NCH], per_addr/per_din/per_en/per_wen,
//        per_dout (read data), clk_en[NCH] (registered strobes).
module clk_en_gen
  import clk_en_gen_pkg::*;
#(
  parameter int         NCH         = 4,
  parameter int         DIV_W       = 8,
  parameter int         SYNC_STAGES = 2,
  parameter logic [8:0] BASE_ADDR   = 9'h0A0
) (
  input  logic           mclk,
  input  logic           reset_n,
  input  logic           lfxt_clk,
  input  logic           oscoff,
  input  logic [NCH-1:0] gate,
  input  logic [7:0]     per_addr,
  input  logic [15:0]    per_din,
  input  logic           per_en,
  input  logic [1:0]     per_wen,
  output logic [15:0]    per_dout,
  output logic [NCH-1:0] clk_en
);

  localparam int SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN :
                          (SYNC_STAGES > SYNC_MAX) ? SYNC_MAX : SYNC_STAGES;
  localparam logic [7:0]  BASE_WADDR = BASE_ADDR[8:1];
  localparam logic [15:0] CTRL_MASK  = ctrl_mask(DIV_W);
  localparam logic [15:0] CTRL_INIT  = CTRL_RST & CTRL_MASK;

  logic [15:0]    ctrl_q [NCH];
  logic [NCH-1:0] hit;
  logic [NCH-1:0] wr_hit;
  logic           rd_en;

  // Address decode
  always_comb begin
    hit    = '0;
    wr_hit = '0;
    for (int n = 0; n < NCH; n++) begin
      hit[n]    = per_en && (per_addr == (BASE_WADDR + 8'(n)));
      wr_hit[n] = hit[n] && (per_wen != 2'b00);
    end
  end

  assign rd_en = per_en && (per_wen == 2'b00);

  // Register file, independent byte lanes
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NCH; n++) ctrl_q[n] <= CTRL_INIT;
    end else begin
      for (int n = 0; n < NCH; n++) begin
        for (int b = 0; b < 2; b++) begin
          if (hit[n] && per_wen[b])
            ctrl_q[n][8*b +: 8] <= per_din[8*b +: 8] & CTRL_MASK[8*b +: 8];
        end
      end
    end
  end

  // Read mux: zero for writes and unmapped addresses
  always_comb begin
    per_dout = '0;
    for (int n = 0; n < NCH; n++) begin
      if (rd_en && hit[n]) per_dout = ctrl_q[n];
    end
  end

  // LFXT synchroniser plus one flop for rising-edge detection
  logic [SYNC_N-1:0] sync_q;
  logic              lfxt_last_q;
  logic              lfxt_tick;

  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q      <= '0;
      lfxt_last_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_N-2:0], lfxt_clk};
      lfxt_last_q <= sync_q[SYNC_N-1];
    end
  end

  assign lfxt_tick = sync_q[SYNC_N-1] & ~lfxt_last_q & ~oscoff;

  // Per-channel dividers
  for (genvar n = 0; n < NCH; n++) begin : g_ch
    logic ch_en;
    logic ch_sel;
    logic ch_src;
    logic ch_clr;

    assign ch_en  = ctrl_q[n][EN_BIT];
    assign ch_sel = ctrl_q[n][SEL_BIT];
    assign ch_src = ch_en & ~gate[n] & (ch_sel ? lfxt_tick : 1'b1);
    // Disabled channels are held at count 0 so re-enabling starts a fresh period.
    assign ch_clr = wr_hit[n] | ~ch_en;

    clk_en_div #(.DIV_W(DIV_W)) u_div (
      .mclk    (mclk),
      .reset_n (reset_n),
      .src     (ch_src),
      .clr     (ch_clr),
      .div     (ctrl_q[n][DIV_W-1:0]),
      .clk_en  (clk_en[n])
    );
  end

endmodule

// File: tb/tb_clk_en_gen.sv
module tb_clk_en_gen;

  localparam int         NCH  = 4;
  localparam int         S    = 2;
  localparam logic [7:0] BW   = 8'h50;
  localparam logic [15:0] MASK = 16'hC0FF;

  logic           mclk     = 1'b0;
  logic           reset_n  = 1'b0;
  logic           lfxt_clk = 1'b0;
  logic           oscoff   = 1'b0;
  logic [NCH-1:0] gate     = '0;
  logic [7:0]     per_addr = '0;
  logic [15:0]    per_din  = '0;
  logic           per_en   = 1'b0;
  logic [1:0]     per_wen  = '0;
  logic [15:0]    per_dout;
  logic [NCH-1:0] clk_en;

  clk_en_gen #(.NCH(NCH), .DIV_W(8), .SYNC_STAGES(S), .BASE_ADDR(9'h0A0)) dut (
    .mclk     (mclk),
    .reset_n  (reset_n),
    .lfxt_clk (lfxt_clk),
    .oscoff   (oscoff),
    .gate     (gate),
    .per_addr (per_addr),
    .per_din  (per_din),
    .per_en   (per_en),
    .per_wen  (per_wen),
    .per_dout (per_dout),
    .clk_en   (clk_en)
  );

  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: register contents, source ticks seen since last clear,
  // and the history of lfxt_clk as sampled on mclk edges.
  logic [15:0]  ctrl_m [NCH];
  int unsigned  ticks  [NCH];
  logic         hist   [$];
  int           lf_half = 10;
  int           lf_cnt  = 0;

  task automatic model_reset();
    for (int n = 0; n < NCH; n++) begin
      ctrl_m[n] = 16'h8000;
      ticks[n]  = 0;
    end
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(1'b0);
  endtask

  task automatic bus_idle();
    per_en   = 1'b0;
    per_wen  = 2'b00;
    per_addr = 8'h00;
    per_din  = 16'h0000;
  endtask

  // One mclk cycle: called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    logic [15:0]    exp_dout;
    logic [NCH-1:0] exp_en;
    logic           tick;
    logic           wr;
    logic           src;
    logic [15:0]    nv;
    int             L;
    int             div;
    #1;
    exp_dout = 16'h0000;
    if (per_en && per_wen == 2'b00 && per_addr >= BW && per_addr < BW + NCH)
      exp_dout = ctrl_m[per_addr - BW];
    chk("per_dout", per_dout, exp_dout);

    // An LFXT rising edge is seen S edges after it was first sampled.
    L    = hist.size();
    tick = hist[L-S] & ~hist[L-S-1] & ~oscoff;

    exp_en = '0;
    for (int n = 0; n < NCH; n++) begin
      wr  = per_en && (per_addr == BW + 8'(n)) && (per_wen != 2'b00);
      div = int'(ctrl_m[n][7:0]);
      if (wr || !ctrl_m[n][15]) begin
        ticks[n] = 0;
      end else begin
        src = !gate[n] && (ctrl_m[n][14] ? tick : 1'b1);
        if (src) begin
          ticks[n]  = ticks[n] + 1;
          exp_en[n] = (ticks[n] % (div + 1)) == 0;
        end
      end
      if (wr) begin
        nv = ctrl_m[n];
        if (per_wen[0]) nv[7:0]  = per_din[7:0];
        if (per_wen[1]) nv[15:8] = per_din[15:8];
        ctrl_m[n] = nv & MASK;
      end
    end

    @(posedge mclk);
    hist.push_back(lfxt_clk);
    if (hist.size() > 12) void'(hist.pop_front());
    #1;
    chk("clk_en", 16'(clk_en), 16'(exp_en));
    @(negedge mclk);
    lf_cnt++;
    if (lf_cnt >= lf_half) begin
      lf_cnt   = 0;
      lfxt_clk = ~lfxt_clk;
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [15:0] d, input logic [1:0] w);
    per_en = 1'b1; per_addr = a; per_din = d; per_wen = w;
    cycle();
    bus_idle();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int first;
    int cnt;
    int r;
    model_reset();
    bus_idle();
    repeat (2) @(negedge mclk);
    chk("rst_clk_en", 16'(clk_en), 16'h0000);
    per_en = 1'b1; per_addr = BW;
    #1;
    chk("rst_ctrl0", per_dout, 16'h8000);
    bus_idle();
    @(negedge mclk);
    reset_n = 1'b1;
    cycle();
    chk("rst_first_edge", 16'(clk_en), 16'h000F);
    repeat (3) cycle();

    // mclk source, DIV=4: first strobe five cycles after the write
    bus_wr(BW + 8'd1, 16'h8004, 2'b11);
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      if (clk_en[1] && first == 0) first = k;
    end
    chk("div4_first", 16'(first), 16'd5);

    // DIV=3 with a 10-cycle gate mid-count
    bus_wr(BW + 8'd1, 16'h8003, 2'b11);
    for (int k = 0; k < 8 && !clk_en[1]; k++) cycle();
    cnt = 0;
    repeat (2) begin cycle(); cnt++; end
    gate[1] = 1'b1;
    repeat (10) begin cycle(); cnt++; end
    gate[1] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      cycle(); cnt++;
      if (clk_en[1]) break;
    end
    chk("gate_gap", 16'(cnt), 16'd14);

    // Low byte write to CTRL3 while it strobes every cycle
    bus_wr(BW + 8'd3, 16'h5502, 2'b01);
    first = 0;
    for (int k = 1; k <= 6; k++) begin
      if (k == 1) begin per_en = 1'b1; per_addr = BW + 8'd3; end
      if (k == 1) begin #1; chk("ctrl3_byte", per_dout, 16'h8002); end
      cycle();
      bus_idle();
      if (clk_en[3] && first == 0) first = k;
    end
    chk("byte_wr_next", 16'(first), 16'd3);

    // LFXT source, DIV=1, lfxt period 20 mclk
    bus_wr(BW + 8'd2, 16'hC001, 2'b11);
    cnt = 0;
    repeat (200) begin cycle(); if (clk_en[2]) cnt++; end
    chk("lfxt_strobes", 16'(cnt), 16'd5);
    oscoff = 1'b1;
    cnt = 0;
    repeat (60) begin cycle(); if (clk_en[2]) cnt++; end
    chk("oscoff_strobes", 16'(cnt), 16'd0);
    oscoff = 1'b0;
    repeat (80) cycle();

    // Reads outside the window and during writes return zero
    per_en = 1'b1; per_addr = BW - 8'd1; cycle();
    per_addr = BW + NCH; cycle();
    per_addr = 8'h00; cycle();
    per_addr = BW; per_wen = 2'b01; per_din = 16'h0000; cycle();
    bus_idle();
    repeat (3) cycle();

    // Reset mid-count aborts with no partial strobe
    @(posedge mclk);
    #3 reset_n = 1'b0;
    #1 chk("rst_abort", 16'(clk_en), 16'h0000);
    @(negedge mclk);
    model_reset();
    reset_n = 1'b1;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 15));
      if (r < 2) begin
        per_en   = 1'b1;
        per_addr = BW - 8'd1 + 8'($urandom_range(0, NCH + 1));
        per_wen  = 2'($urandom_range(1, 3));
        per_din  = 16'($urandom);
        per_din[15] = ($urandom_range(0, 7) != 0);
        if ($urandom_range(0, 3) != 0) per_din[7:0] = 8'($urandom_range(0, 6));
      end else if (r < 5) begin
        per_en   = 1'b1;
        per_addr = BW - 8'd1 + 8'($urandom_range(0, NCH + 1));
        per_wen  = 2'b00;
      end else begin
        bus_idle();
      end
      if ($urandom_range(0, 15) == 0) gate[$urandom_range(0, NCH - 1)] ^= 1'b1;
      if ($urandom_range(0, 63) == 0) oscoff = ~oscoff;
      if (lf_cnt == 0) lf_half = int'($urandom_range(1, 12));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
